// File: rtl/poly_note_player.sv
// Polyphonic note player: voice allocation, beat-based note durations, sawtooth phase accumulators and a mixed sample output.
// Optional voice stealing when all voices are busy: define POLY_NOTE_PLAYER_VOICE_STEAL_EN.
module poly_note_player #(
   parameter int VOICES   = 4,
   parameter int DUR_W    = 6,
   parameter int PHASE_W  = 20,
   parameter int SAMPLE_W = 16
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         play_enable,
   input  logic                                         load_new_note,
   input  logic [PHASE_W-1:0]                           step_to_load,
   input  logic [DUR_W-1:0]                             duration_to_load,
   output logic                                         load_ready,
   output logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] load_voice,
   output logic [VOICES-1:0]                            voice_busy,
   input  logic                                         beat,
   output logic                                         done_with_note,
   output logic [VOICES-1:0]                            done_voice,
   input  logic                                         generate_next_sample,
   output logic signed [SAMPLE_W-1:0]                   sample_out,
   output logic                                         new_sample_ready
);

   localparam int SH    = $clog2(VOICES);
   localparam int LV_W  = (VOICES > 1) ? SH : 1;
   localparam int SUM_W = SAMPLE_W + SH;

   logic [VOICES-1:0]         busy;
   logic [PHASE_W-1:0]        step  [VOICES];
   logic [PHASE_W-1:0]        phase [VOICES];
   logic [DUR_W-1:0]          count [VOICES];
   logic                      any_free;
   logic [LV_W-1:0]           free_idx;
   logic [LV_W-1:0]           target;
   logic                      load_acc;
   logic [VOICES-1:0]         expire;
   logic                      req_p0;
   logic                      vld_p1;
   logic signed [SAMPLE_W-1:0] v_p1 [VOICES];
   logic signed [SUM_W-1:0]   sum_p1;

   // Sawtooth: phase 0 maps to the most negative sample.
   function automatic logic signed [SAMPLE_W-1:0] saw(input logic [PHASE_W-1:0] ph);
      return {~ph[PHASE_W-1], ph[PHASE_W-2 -: SAMPLE_W-1]};
   endfunction

   function automatic logic signed [SAMPLE_W-1:0] scale_mix(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] sh;
      sh = s >>> SH;
      return sh[SAMPLE_W-1:0];
   endfunction

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = VOICES - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            any_free = 1'b1;
            free_idx = LV_W'(i);
         end
      end
   end

`ifdef POLY_NOTE_PLAYER_VOICE_STEAL_EN
   logic [LV_W-1:0] steal_ptr;

   assign load_ready = reset & play_enable;
   assign target     = any_free ? free_idx : steal_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         steal_ptr <= '0;
      end else if (!play_enable) begin
         steal_ptr <= '0;
      end else if (load_acc && !any_free) begin
         steal_ptr <= (steal_ptr == LV_W'(VOICES - 1)) ? '0 : steal_ptr + LV_W'(1);
      end
   end
`else
   assign load_ready = reset & play_enable & any_free;
   assign target     = free_idx;
`endif

   assign load_acc   = load_new_note & load_ready & (duration_to_load != '0);
   assign voice_busy = busy;
   assign req_p0     = generate_next_sample & ~vld_p1;

   // A voice being (re)loaded this cycle never reports an expiry, which also hides stolen voices.
   always_comb begin
      expire = '0;
      for (int i = 0; i < VOICES; i++) begin
         expire[i] = play_enable & beat & busy[i] & (count[i] == DUR_W'(1))
                     & ~(load_acc & (target == LV_W'(i)));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy           <= '0;
         load_voice     <= '0;
         done_with_note <= 1'b0;
         done_voice     <= '0;
         for (int i = 0; i < VOICES; i++) begin
            step[i]  <= '0;
            phase[i] <= '0;
            count[i] <= '0;
         end
      end else begin
         done_voice     <= expire;
         done_with_note <= |expire;
         if (load_acc) load_voice <= target;
         for (int i = 0; i < VOICES; i++) begin
            if (load_acc && (target == LV_W'(i))) begin
               busy[i]  <= 1'b1;
               step[i]  <= step_to_load;
               phase[i] <= '0;
               count[i] <= duration_to_load;
            end else if (!play_enable) begin
               busy[i]  <= 1'b0;
               phase[i] <= '0;
               count[i] <= '0;
            end else if (expire[i]) begin
               busy[i]  <= 1'b0;
               phase[i] <= '0;
               count[i] <= '0;
            end else begin
               if (beat && busy[i]) count[i] <= count[i] - DUR_W'(1);
               if (req_p0 && busy[i]) phase[i] <= phase[i] + step[i];
            end
         end
      end
   end

   // Stage p0 -> p1: advance phases and capture each voice's contribution.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1 <= 1'b0;
         for (int i = 0; i < VOICES; i++) v_p1[i] <= '0;
      end else begin
         vld_p1 <= req_p0;
         if (req_p0) begin
            for (int i = 0; i < VOICES; i++) begin
               v_p1[i] <= (busy[i] && play_enable) ? saw(phase[i] + step[i]) : '0;
            end
         end
      end
   end

   always_comb begin
      sum_p1 = '0;
      for (int i = 0; i < VOICES; i++) sum_p1 = sum_p1 + SUM_W'(v_p1[i]);
   end

   // Stage p1 -> p2: register the mixed sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_out       <= '0;
         new_sample_ready <= 1'b0;
      end else begin
         new_sample_ready <= vld_p1;
         if (vld_p1) sample_out <= scale_mix(sum_p1);
      end
   end

endmodule

// File: tb/tb_poly_note_player.sv
// Directed bench for poly_note_player (VOICES=4); covers the steal build when POLY_NOTE_PLAYER_VOICE_STEAL_EN is defined.
module tb_poly_note_player;

   logic        clk;
   logic        reset;
   logic        play_enable;
   logic        load_new_note;
   logic [19:0] step_to_load;
   logic [5:0]  duration_to_load;
   logic        load_ready;
   logic [1:0]  load_voice;
   logic [3:0]  voice_busy;
   logic        beat;
   logic        done_with_note;
   logic [3:0]  done_voice;
   logic        generate_next_sample;
   logic [15:0] sample_out;
   logic        new_sample_ready;

   int checks;
   int failures;

   poly_note_player #(.VOICES(4), .DUR_W(6), .PHASE_W(20), .SAMPLE_W(16)) dut (
      .clk(clk),
      .reset(reset),
      .play_enable(play_enable),
      .load_new_note(load_new_note),
      .step_to_load(step_to_load),
      .duration_to_load(duration_to_load),
      .load_ready(load_ready),
      .load_voice(load_voice),
      .voice_busy(voice_busy),
      .beat(beat),
      .done_with_note(done_with_note),
      .done_voice(done_voice),
      .generate_next_sample(generate_next_sample),
      .sample_out(sample_out),
      .new_sample_ready(new_sample_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_note(input logic [19:0] s, input logic [5:0] d);
      load_new_note    = 1'b1;
      step_to_load     = s;
      duration_to_load = d;
      tick();
      load_new_note    = 1'b0;
   endtask

   task automatic do_beat();
      beat = 1'b1;
      tick();
      beat = 1'b0;
   endtask

   // Issues one request and checks the pipeline timing and the resulting sample.
   task automatic request(input string tag, input logic [15:0] exp);
      generate_next_sample = 1'b1;
      tick();
      generate_next_sample = 1'b0;
      chk({tag, "_rdy_t1"}, 32'(new_sample_ready), 32'd0);
      tick();
      chk({tag, "_rdy_t2"}, 32'(new_sample_ready), 32'd1);
      chk({tag, "_sample"}, 32'(sample_out), 32'(exp));
      tick();
      chk({tag, "_rdy_t3"}, 32'(new_sample_ready), 32'd0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      play_enable = 1'b1;
      load_new_note = 1'b0;
      step_to_load = '0;
      duration_to_load = '0;
      beat = 1'b0;
      generate_next_sample = 1'b0;
      tick();
      tick();
      chk("rst_load_ready", 32'(load_ready), 32'd0);
      chk("rst_busy", 32'(voice_busy), 32'd0);
      chk("rst_done", 32'(done_with_note), 32'd0);
      chk("rst_sample", 32'(sample_out), 32'd0);
      chk("rst_nsr", 32'(new_sample_ready), 32'd0);
      reset = 1'b1;
      tick();
      chk("ready_after_rst", 32'(load_ready), 32'd1);

      // Single voice, 3 beats.
      load_note(20'h00100, 6'd3);
      chk("single_busy", 32'(voice_busy), 32'h1);
      chk("single_lv", 32'(load_voice), 32'd0);
      do_beat();
      chk("beat1_done", 32'(done_with_note), 32'd0);
      do_beat();
      chk("beat2_busy", 32'(voice_busy), 32'h1);
      do_beat();
      chk("beat3_done", 32'(done_with_note), 32'd1);
      chk("beat3_mask", 32'(done_voice), 32'h1);
      chk("beat3_busy", 32'(voice_busy), 32'h0);
      tick();
      chk("done_cleared", 32'(done_with_note), 32'd0);
      chk("mask_cleared", 32'(done_voice), 32'h0);

      // Sample pipeline with one voice at half-scale step.
      load_note(20'h80000, 6'd63);
      request("req1", 16'h0000);
      request("req2", 16'hE000);
      // Request held two cycles: second cycle is dropped, one advance only.
      generate_next_sample = 1'b1;
      tick();
      tick();
      generate_next_sample = 1'b0;
      chk("hold_rdy", 32'(new_sample_ready), 32'd1);
      chk("hold_sample", 32'(sample_out), 32'h0000);
      tick();
      chk("hold_no_second", 32'(new_sample_ready), 32'd0);
      tick();
      chk("hold_no_third", 32'(new_sample_ready), 32'd0);
      request("req4", 16'hE000);
      load_note(20'h40000, 6'd63);
      chk("two_lv", 32'(load_voice), 32'd1);
      request("mix2", 16'hF000);

      // Fill remaining voices.
      load_note(20'h00010, 6'd63);
      chk("fill_lv2", 32'(load_voice), 32'd2);
      load_note(20'h00010, 6'd63);
      chk("fill_lv3", 32'(load_voice), 32'd3);
      chk("fill_busy", 32'(voice_busy), 32'hF);
`ifdef POLY_NOTE_PLAYER_VOICE_STEAL_EN
      chk("steal_ready", 32'(load_ready), 32'd1);
      load_note(20'h00020, 6'd63);
      chk("steal1_lv", 32'(load_voice), 32'd0);
      chk("steal1_done", 32'(done_with_note), 32'd0);
      load_note(20'h00020, 6'd63);
      chk("steal2_lv", 32'(load_voice), 32'd1);
      chk("steal2_done", 32'(done_with_note), 32'd0);
      chk("steal_busy", 32'(voice_busy), 32'hF);
`else
      chk("full_ready", 32'(load_ready), 32'd0);
      load_note(20'h00020, 6'd63);
      chk("refuse_busy", 32'(voice_busy), 32'hF);
      chk("refuse_lv", 32'(load_voice), 32'd3);
`endif

      // play_enable drop clears everything; request still answered with 0.
      play_enable = 1'b0;
      tick();
      chk("drop_busy", 32'(voice_busy), 32'h0);
      chk("drop_ready", 32'(load_ready), 32'd0);
      chk("drop_done", 32'(done_with_note), 32'd0);
      request("drop_req", 16'h0000);
      play_enable = 1'b1;
      tick();
      chk("resume_ready", 32'(load_ready), 32'd1);

      // Load on the same cycle as a beat expiring another voice.
      load_note(20'h00100, 6'd1);
      chk("sim_pre_lv", 32'(load_voice), 32'd0);
      beat = 1'b1;
      load_note(20'h00100, 6'd2);
      beat = 1'b0;
      chk("sim_done", 32'(done_with_note), 32'd1);
      chk("sim_mask", 32'(done_voice), 32'h1);
      chk("sim_busy", 32'(voice_busy), 32'h2);
      chk("sim_lv", 32'(load_voice), 32'd1);
      do_beat();
      chk("sim_b1_done", 32'(done_with_note), 32'd0);
      chk("sim_b1_busy", 32'(voice_busy), 32'h2);
      do_beat();
      chk("sim_b2_mask", 32'(done_voice), 32'h2);
      chk("sim_b2_busy", 32'(voice_busy), 32'h0);
      load_note(20'h00100, 6'd0);
      chk("zero_dur_busy", 32'(voice_busy), 32'h0);
      chk("zero_dur_lv", 32'(load_voice), 32'd1);

      // Expiring voice while play_enable drops: no done pulse.
      load_note(20'h00100, 6'd1);
      play_enable = 1'b0;
      do_beat();
      chk("drop_beat_done", 32'(done_with_note), 32'd0);
      chk("drop_beat_busy", 32'(voice_busy), 32'h0);
      play_enable = 1'b1;
      tick();

      // Asynchronous reset mid-note.
      load_note(20'h00100, 6'd10);
      chk("pre_arst_busy", 32'(voice_busy), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", 32'(voice_busy), 32'h0);
      chk("arst_ready", 32'(load_ready), 32'd0);
      chk("arst_lv", 32'(load_voice), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/poly_note_player.md
# poly_note_player

Polyphonic note player that replaces the single-voice note/timer path. It accepts notes as pre-computed phase steps with beat durations and allocates each note to a free voice. Each voice runs a phase accumulator and a beat-based duration counter, and the block mixes all voices into one signed sample for the codec on each `generate_next_sample` request. It sits between the song sequencer (beat and note source) and the codec interface.

## Interface
Parameters:
- `VOICES`, 4: number of voices; power of two, 1..8.
- `DUR_W`, 6: duration width, in beats.
- `PHASE_W`, 20: phase accumulator and step width.
- `SAMPLE_W`, 16: sample width; must satisfy `SAMPLE_W` ≤ `PHASE_W`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `play_enable` in 1: high plays; low clears all voices synchronously.
- `load_new_note` in 1: one-cycle load request.
- `step_to_load` in `PHASE_W`: phase increment for the new note.
- `duration_to_load` in `DUR_W`: note length in beats; 0 is illegal.
- `load_ready` out 1: a load will be accepted this cycle.
- `load_voice` out clog2(`VOICES`) (min 1): voice taken by the last accepted load.
- `voice_busy` out `VOICES`: per-voice active flags.
- `beat` in 1: one-cycle 1/48 s beat strobe.
- `done_with_note` out 1: one-cycle pulse when one or more voices expire.
- `done_voice` out `VOICES`: mask of the voices that expired; valid with `done_with_note`.
- `generate_next_sample` in 1: one-cycle codec request.
- `sample_out` out `SAMPLE_W`: signed mixed sample.
- `new_sample_ready` out 1: one-cycle pulse; `sample_out` is valid.

## Operation
- Reset value of every output is 0; `load_ready` is 0 during reset.
- Per-voice state: `busy`, `step[PHASE_W]`, `phase[PHASE_W]`, `count[DUR_W]`.

Load:
- A load is accepted when `load_new_note` && `load_ready` && `play_enable` && `duration_to_load` ≠ 0.
- The target is the lowest-index voice that is not busy.
- On accept, the target gets `busy`=1, `step`=`step_to_load`, `phase`=0 and `count`=`duration_to_load`, and `load_voice` is updated.
- Rejected loads (including duration 0) change no state.
- `load_ready` = `play_enable` && (any voice free).

Duration:
- On `beat`, each busy voice does the following:
  - If `count`==1: clear `busy`, clear `phase`, set its `done_voice` bit, and pulse `done_with_note` the next cycle.
  - Otherwise: decrement `count`.
- If a voice is loaded in the same cycle as `beat`, the load wins. The loaded count is not decremented that cycle.
- Several voices may expire on the same beat; all of their bits are set in `done_voice`.

Sample path:
- A busy voice's waveform is a sawtooth: `v` = {~`phase[PHASE_W-1]`, `phase[PHASE_W-2 -: SAMPLE_W-1]`}.
  - `phase` 0 gives `v` = -2^(`SAMPLE_W`-1).
- A free voice contributes 0.
- Mix: the sign-extended sum of all `v` (width `SAMPLE_W`+clog2(`VOICES`)), arithmetically shifted right by clog2(`VOICES`).
- Phase arithmetic wraps modulo 2^`PHASE_W`.

`play_enable` low:
- All `busy`, `phase` and `count` are cleared the next cycle.
- No done pulse is generated.
- Sample requests are still answered, with `sample_out`=0.

## Timing
- Load accepted at edge T: `voice_busy` bit and `load_voice` are visible after T.
- Beat at T: `done_with_note` and `done_voice` are high for the single cycle T+1, then return to 0.
- Sample request:
  - Cycle T: `generate_next_sample` is high.
  - Edge T+1: every busy voice does `phase` += `step`.
  - Edge T+2: mix is registered into `sample_out` and `new_sample_ready` is high for one cycle.
  - `sample_out` holds until the next request.
- A request arriving while the previous one is still in flight (T+1) is dropped; the codec interval is far longer than two cycles.
- A load or expire during the pipeline affects the next sample, not the one in flight.
- Reset assertion at any time returns all state to reset values immediately. Release is synchronized by the system's reset synchronizer.

## Configuration
- Macro: `POLY_NOTE_PLAYER_VOICE_STEAL_EN`.
- Defined:
  - `load_ready` = `play_enable`, regardless of voice occupancy.
  - When all voices are busy, the load overwrites voice `steal_ptr` and `steal_ptr` increments modulo `VOICES`.
  - A stolen voice produces no done pulse.
  - `steal_ptr` resets to 0 and also clears on `play_enable` low.
- Undefined: loads are refused when all voices are busy (`load_ready`=0).

## Test plan
- Reset and single voice: release reset, `play_enable`=1, load step=0x00100, duration=3.
  - Expect `voice_busy`=0001 and `load_voice`=0.
  - After 3 beats: `done_with_note` is a one-cycle pulse with `done_voice`=0001, and `voice_busy`=0.
- Sample pipeline, `VOICES`=4, one voice step=0x80000:
  - First request: `sample_out`=(0x0000 + 0)>>>2 = 0x0000 at T+2, `new_sample_ready` one cycle.
  - Second request: -32768>>>2 = 0xE000.
- Fill and refuse (macro undefined): load 5 notes. The first 4 occupy voices 0..3; `load_ready`=0; the 5th is ignored and `voice_busy`=1111.
- Steal (macro defined): with 4 busy, load twice. The loads go to voice 0 then voice 1; `done_with_note` is never asserted.
- Simultaneous events: load duration=2 on the same cycle as `beat`, with another voice at `count`=1.
  - The new voice keeps `count`=2; the other voice expires with its `done_voice` bit set.
  - A duration=0 load is rejected.
- `play_enable` drop mid-note: all `voice_busy`→0 the next cycle, no done pulse, and a subsequent request returns `sample_out`=0 with `new_sample_ready`.
